// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bundle: D-stage redirect inputs, stall/exception
// controls and the fetch-side outputs.
interface fetch_pc_unit_if;
   logic        stall;
   logic [3:0]  pcsel_d;
   logic        cmp_eq_d;
   logic [31:0] imm_d;
   logic [25:0] instr_index_d;
   logic [31:0] pc_d;
   logic [31:0] rs_val_d;
   logic [31:0] epc;
   logic        exc_req;
   logic [31:0] pc_f;
   logic        adel_f;
   logic        flush_d;
   logic        redirect;
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;

   modport master (
      output stall, pcsel_d, cmp_eq_d, imm_d, instr_index_d,
      output pc_d, rs_val_d, epc, exc_req,
      input  pc_f, adel_f, flush_d, redirect,
      input  fetch_cnt, redirect_cnt
   );

   modport slave (
      input  stall, pcsel_d, cmp_eq_d, imm_d, instr_index_d,
      input  pc_d, rs_val_d, epc, exc_req,
      output pc_f, adel_f, flush_d, redirect,
      output fetch_cnt, redirect_cnt
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// F-stage PC register and next-PC selector for the MIPS pipeline.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_LO     = 32'h0000_3000,
   parameter logic [31:0] IM_HI     = 32'h0000_6ffc
) (
   input logic           clk,
   input logic           reset,
   fetch_pc_unit_if.slave bus
);

   localparam logic [3:0] SEL_BEQ  = 4'd1;
   localparam logic [3:0] SEL_JAL  = 4'd2;
   localparam logic [3:0] SEL_JR   = 4'd3;
   localparam logic [3:0] SEL_ERET = 4'd4;

   logic [31:0] pc;
   logic [31:0] npc;
   logic [31:0] seq_pc;
   logic [31:0] beq_pc;
   logic [31:0] jal_pc;
   logic        flush;
   logic        redir;

   logic        is_beq;
   logic        is_jal;
   logic        is_jr;
   logic        is_eret;

   logic        take_exc;
   logic        take_eret;
   logic        take_hold;
   logic        take_beq;
   logic        take_jal;
   logic        take_jr;

   assign is_beq  = (bus.pcsel_d == SEL_BEQ);
   assign is_jal  = (bus.pcsel_d == SEL_JAL);
   assign is_jr   = (bus.pcsel_d == SEL_JR);
   assign is_eret = (bus.pcsel_d == SEL_ERET);

   // One-hot select in priority order; exceptions beat stall.
   assign take_exc  = bus.exc_req;
   assign take_eret = !bus.exc_req && !bus.stall && is_eret;
   assign take_hold = !bus.exc_req && bus.stall;
   assign take_beq  = !bus.exc_req && !bus.stall
                      && is_beq && bus.cmp_eq_d;
   assign take_jal  = !bus.exc_req && !bus.stall && is_jal;
   assign take_jr   = !bus.exc_req && !bus.stall && is_jr;

   assign seq_pc = pc + 32'd4;
   assign beq_pc = bus.pc_d + 32'd4 + {bus.imm_d[29:0], 2'b00};
   assign jal_pc = {bus.pc_d[31:28], bus.instr_index_d, 2'b00};

   always_comb begin
      npc   = seq_pc;
      flush = 1'b0;
      redir = 1'b0;
      unique case (1'b1)
         take_exc: begin
            npc   = EXC_ENTRY;
            flush = 1'b1;
            redir = 1'b1;
         end
         take_eret: begin
            npc   = bus.epc;
            flush = 1'b1;
            redir = 1'b1;
         end
         take_hold: begin
            npc = pc;
         end
         take_beq: begin
            npc   = beq_pc;
            redir = 1'b1;
         end
         take_jal: begin
            npc   = jal_pc;
            redir = 1'b1;
         end
         take_jr: begin
            npc   = bus.rs_val_d;
            redir = 1'b1;
         end
         default: begin
            npc = seq_pc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= npc;
      end
   end

   assign bus.pc_f     = pc;
   assign bus.flush_d  = flush;
   assign bus.redirect = redir;
   assign bus.adel_f   = (pc[1:0] != 2'b00)
                         || (pc < IM_LO)
                         || (pc > IM_HI);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_q;
   logic [31:0] redir_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_q <= 32'd0;
         redir_q <= 32'd0;
      end else begin
         if (!bus.stall || bus.exc_req) begin
            fetch_q <= fetch_q + 32'd1;
         end
         if (redir) begin
            redir_q <= redir_q + 32'd1;
         end
      end
   end

   assign bus.fetch_cnt    = fetch_q;
   assign bus.redirect_cnt = redir_q;
`else
   assign bus.fetch_cnt    = 32'd0;
   assign bus.redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit.
// Counter checks follow FETCH_PERF_CNT_EN.
module tb_fetch_pc_unit;

   logic clk;
   logic reset;
   int   vec_cnt;
   int   err_cnt;
   logic [31:0] exp_fetch;
   logic [31:0] exp_red;

   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit redir);
      if (!bus.stall || bus.exc_req) exp_fetch++;
      if (redir) exp_red++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.stall    = 1'b0;
      bus.pcsel_d  = 4'd0;
      bus.cmp_eq_d = 1'b0;
      bus.exc_req  = 1'b0;
   endtask

   function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      exp_fetch = 0;
      exp_red   = 0;
      reset     = 1'b0;
      idle();
      bus.imm_d         = 32'd0;
      bus.instr_index_d = 26'd0;
      bus.pc_d          = 32'd0;
      bus.rs_val_d      = 32'd0;
      bus.epc           = 32'd0;

      #12;
      check("rst_pc", bus.pc_f, 32'h3000);
      check("rst_adel", {31'd0, bus.adel_f}, 32'd0);
      check("rst_flush", {31'd0, bus.flush_d}, 32'd0);
      check("rst_redir", {31'd0, bus.redirect}, 32'd0);
      check("rst_fcnt", bus.fetch_cnt, 32'd0);
      check("rst_rcnt", bus.redirect_cnt, 32'd0);
      reset = 1'b1;

      step(0);
      check("seq1", bus.pc_f, 32'h3004);
      step(0);
      check("seq2", bus.pc_f, 32'h3008);
      check("seq_adel", {31'd0, bus.adel_f}, 32'd0);

      bus.pcsel_d  = 4'd1;
      bus.pc_d     = 32'h3008;
      bus.imm_d    = 32'hffff_fffe;
      bus.cmp_eq_d = 1'b1;
      #1;
      check("beq_redir", {31'd0, bus.redirect}, 32'd1);
      check("beq_flush", {31'd0, bus.flush_d}, 32'd0);
      step(1);
      check("beq_pc", bus.pc_f, 32'h3004);
      bus.cmp_eq_d = 1'b0;
      #1;
      check("bne_redir", {31'd0, bus.redirect}, 32'd0);
      step(0);
      check("bne_pc", bus.pc_f, 32'h3008);

      bus.pcsel_d       = 4'd2;
      bus.pc_d          = 32'h3010;
      bus.instr_index_d = 26'h0000c10;
      step(1);
      check("jal_pc", bus.pc_f, 32'h3040);

      bus.pcsel_d  = 4'd3;
      bus.rs_val_d = 32'h300c;
      step(1);
      check("jr_pc", bus.pc_f, 32'h300c);

      idle();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0);
         check("stall_pc", bus.pc_f, 32'h300c);
      end
      check("stall_redir", {31'd0, bus.redirect}, 32'd0);
      bus.exc_req = 1'b1;
      #1;
      check("exc_flush", {31'd0, bus.flush_d}, 32'd1);
      check("exc_redir", {31'd0, bus.redirect}, 32'd1);
      step(1);
      check("exc_pc", bus.pc_f, 32'h4180);
      idle();

      bus.pcsel_d  = 4'd3;
      bus.rs_val_d = 32'h3001;
      step(1);
      check("jr_mis_pc", bus.pc_f, 32'h3001);
      check("jr_mis_adel", {31'd0, bus.adel_f}, 32'd1);

      bus.pcsel_d = 4'd4;
      bus.epc     = 32'h3020;
      bus.stall   = 1'b1;
      #1;
      check("eret_st_flush", {31'd0, bus.flush_d}, 32'd0);
      step(0);
      check("eret_st_pc", bus.pc_f, 32'h3001);
      bus.stall = 1'b0;
      #1;
      check("eret_flush", {31'd0, bus.flush_d}, 32'd1);
      step(1);
      check("eret_pc", bus.pc_f, 32'h3020);
      check("eret_adel", {31'd0, bus.adel_f}, 32'd0);

      bus.pcsel_d  = 4'd3;
      bus.rs_val_d = 32'h6ffc;
      step(1);
      check("adel_hi_ok", {31'd0, bus.adel_f}, 32'd0);
      bus.rs_val_d = 32'h7000;
      step(1);
      check("adel_hi_bad", {31'd0, bus.adel_f}, 32'd1);
      bus.rs_val_d = 32'h2ffc;
      step(1);
      check("adel_lo_bad", {31'd0, bus.adel_f}, 32'd1);

      bus.pcsel_d = 4'd7;
      step(0);
      check("odd_sel_pc", bus.pc_f, 32'h3000);

      bus.pcsel_d  = 4'd3;
      bus.rs_val_d = 32'h3050;
      step(1);
      check("pre_rst_pc", bus.pc_f, 32'h3050);
      check("fcnt", bus.fetch_cnt, cnt_exp(exp_fetch));
      check("rcnt", bus.redirect_cnt, cnt_exp(exp_red));
      idle();

      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_pc", bus.pc_f, 32'h3000);
      check("mid_rst_fcnt", bus.fetch_cnt, 32'd0);
      check("mid_rst_rcnt", bus.redirect_cnt, 32'd0);
      @(negedge clk);
      check("rst_hold_pc", bus.pc_f, 32'h3000);
      reset = 1'b1;
      exp_fetch = 0;
      exp_red   = 0;
      step(0);
      check("resume_pc", bus.pc_f, 32'h3004);
      check("resume_fcnt", bus.fetch_cnt, cnt_exp(exp_fetch));

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
